// File: rtl/clk_div_gen_if.sv
// Configuration write port for clk_div_gen.
// Each accepted valid/ready beat programs one channel's period, high time and enable.
interface clk_div_gen_if #(
   parameter int NCH = 4,
   parameter int CW  = 8
);
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

   logic           cfg_valid;
   logic           cfg_ready;
   logic [CHW-1:0] cfg_ch;
   logic [CW-1:0]  cfg_div;
   logic [CW-1:0]  cfg_high;
   logic           cfg_en;

   modport master (
      output cfg_valid, cfg_ch, cfg_div, cfg_high, cfg_en,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_ch, cfg_div, cfg_high, cfg_en,
      output cfg_ready
   );
endinterface

// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock divider / tick generator with glitch-free, boundary-aligned updates.
// Optional macro CLK_DIV_GEN_SYNC_START_EN adds a sync_start input that phase-aligns all channels.
module clk_div_gen #(
   parameter int NCH = 4,
   parameter int CW  = 8
) (
   input  logic            clk,
   input  logic            rst_n,
`ifdef CLK_DIV_GEN_SYNC_START_EN
   input  logic            sync_start,
`endif
   clk_div_gen_if.slave    cfg,
   output logic [NCH-1:0]  clk_out,
   output logic [NCH-1:0]  tick,
   output logic [NCH-1:0]  busy
);
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

   logic [NCH-1:0] pending;
   logic           ready_c;
   logic           cfg_accept;
   logic           sync_go;

`ifdef CLK_DIV_GEN_SYNC_START_EN
   assign sync_go = sync_start;
`else
   assign sync_go = 1'b0;
`endif

   // Out-of-range channel numbers match no channel, so they are always ready and simply dropped.
   always_comb begin
      ready_c = 1'b1;
      for (int i = 0; i < NCH; i++) begin
         if (cfg.cfg_ch == CHW'(i)) begin
            ready_c = !pending[i];
         end
      end
   end

   assign cfg.cfg_ready = ready_c;
   assign cfg_accept    = cfg.cfg_valid && ready_c;
   assign busy          = pending;

   genvar g;
   generate
      for (g = 0; g < NCH; g++) begin : g_ch
         logic          en_q, sh_en, pend_q, clk_q, tick_q;
         logic [CW-1:0] div_q, high_q, cnt_q, sh_div, sh_high;
         logic          en_n;
         logic [CW-1:0] div_n, high_n, cnt_n;
         logic          wr, apply;

         assign wr    = cfg_accept && (cfg.cfg_ch == CHW'(g));
         // A disabled channel has no period to finish, so its update lands on the very next edge.
         assign apply = pend_q && (!en_q || (cnt_q == div_q) || sync_go);

         always_comb begin
            en_n   = en_q;
            div_n  = div_q;
            high_n = high_q;
            cnt_n  = '0;
            if (apply) begin
               en_n   = sh_en;
               div_n  = sh_div;
               high_n = sh_high;
            end else if (en_q && !sync_go && (cnt_q != div_q)) begin
               cnt_n = cnt_q + CW'(1);
            end
         end

         // Outputs are registered from next-state values so they line up with the counter.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               en_q    <= 1'b0;
               div_q   <= '0;
               high_q  <= '0;
               cnt_q   <= '0;
               sh_en   <= 1'b0;
               sh_div  <= '0;
               sh_high <= '0;
               pend_q  <= 1'b0;
               clk_q   <= 1'b0;
               tick_q  <= 1'b0;
            end else begin
               en_q   <= en_n;
               div_q  <= div_n;
               high_q <= high_n;
               cnt_q  <= cnt_n;
               clk_q  <= en_n && (cnt_n < high_n);
               tick_q <= en_n && (cnt_n == '0);
               if (wr) begin
                  sh_en   <= cfg.cfg_en;
                  sh_div  <= cfg.cfg_div;
                  sh_high <= cfg.cfg_high;
                  pend_q  <= 1'b1;
               end else if (apply) begin
                  pend_q  <= 1'b0;
               end
            end
         end

         assign clk_out[g] = clk_q;
         assign tick[g]    = tick_q;
         assign pending[g] = pend_q;
      end
   endgenerate
endmodule

// File: tb/tb_clk_div_gen.sv
// Directed scoreboard bench for clk_div_gen; three channels so an out-of-range channel index exists.
module tb_clk_div_gen;
   localparam int NCH = 3;
   localparam int CW  = 8;
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

   logic           clk = 1'b0;
   logic           rst_n;
`ifdef CLK_DIV_GEN_SYNC_START_EN
   logic           sync_start;
`endif
   logic [NCH-1:0] clk_out;
   logic [NCH-1:0] tick;
   logic [NCH-1:0] busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      tag;
      int         ch;
      logic [2:0] exp;
   } exp_t;

   exp_t sb[$];

   clk_div_gen_if #(.NCH(NCH), .CW(CW)) cfg ();

   clk_div_gen #(.NCH(NCH), .CW(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
`ifdef CLK_DIV_GEN_SYNC_START_EN
      .sync_start (sync_start),
`endif
      .cfg        (cfg),
      .clk_out    (clk_out),
      .tick       (tick),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic apply_stimulus(input logic v, input int ch, input int dv, input int hi, input logic en);
      cfg.cfg_valid = v;
      cfg.cfg_ch    = CHW'(ch);
      cfg.cfg_div   = CW'(dv);
      cfg.cfg_high  = CW'(hi);
      cfg.cfg_en    = en;
   endtask

   task automatic expect_ch(input string tag, input int ch, input logic c, input logic t, input logic b);
      exp_t e;
      e.tag = tag;
      e.ch  = ch;
      e.exp = {c, t, b};
      sb.push_back(e);
   endtask

   // Expected outputs at a given phase of a period: high for the first hi cycles, tick at phase 0.
   task automatic expect_pattern(input string tag, input int ch, input int hi, input int phase, input logic b);
      expect_ch(tag, ch, phase < hi, phase == 0, b);
   endtask

   task automatic expect_all_idle(input string tag);
      for (int c = 0; c < NCH; c++) expect_ch(tag, c, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic check_output();
      exp_t       e;
      logic [2:0] obs;
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = {clk_out[e.ch], tick[e.ch], busy[e.ch]};
         checks++;
         assert (obs === e.exp) else begin
            errors++;
            $error("[TB] FAIL %s ch%0d clk/tick/busy observed=%b expected=%b", e.tag, e.ch, obs, e.exp);
         end
      end
   endtask

   task automatic check_ready(input string tag, input logic exp);
      checks++;
      assert (cfg.cfg_ready === exp) else begin
         errors++;
         $error("[TB] FAIL %s cfg_ready observed=%b expected=%b", tag, cfg.cfg_ready, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      apply_stimulus(1'b0, 0, 0, 0, 1'b0);
      expect_all_idle("reset");
      check_output();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
`ifdef CLK_DIV_GEN_SYNC_START_EN
      sync_start = 1'b0;
`endif
      apply_stimulus(1'b0, 0, 0, 0, 1'b0);
      check_output();
      check_output();
      expect_all_idle("reset_state");
      check_output();
      check_ready("reset_ready", 1'b1);
      rst_n = 1'b1;

      // Enable ch0: div=3 high=2 gives 1100 with a tick every 4th cycle.
      apply_stimulus(1'b1, 0, 3, 2, 1'b1);
      check_ready("t1_ready", 1'b1);
      expect_ch("t1_accept", 0, 1'b0, 1'b0, 1'b1);
      check_output();
      apply_stimulus(1'b0, 0, 3, 2, 1'b1);
      check_ready("t1_stall", 1'b0);
      for (int k = 0; k < 10; k++) begin
         expect_pattern("t1_1100", 0, 2, k % 4, 1'b0);
         check_output();
      end

      // Mid-period update to div=5 high=3; old period must finish first.
      apply_stimulus(1'b1, 0, 5, 3, 1'b1);
      check_ready("t2_ready_before", 1'b1);
      expect_pattern("t2_old", 0, 2, 2, 1'b1);
      check_output();
      apply_stimulus(1'b0, 0, 5, 3, 1'b1);
      check_ready("t2_stall", 1'b0);
      expect_pattern("t2_old", 0, 2, 3, 1'b1);
      check_output();
      check_ready("t2_stall2", 1'b0);
      for (int k = 0; k < 12; k++) begin
         expect_pattern("t2_111000", 0, 3, k % 6, 1'b0);
         check_output();
      end
      check_ready("t2_ready_after", 1'b1);

      // Ch1 div=7 high=4, disabled during its high phase.
      apply_stimulus(1'b1, 1, 7, 4, 1'b1);
      expect_ch("t3_accept", 1, 1'b0, 1'b0, 1'b1);
      check_output();
      apply_stimulus(1'b0, 1, 7, 4, 1'b1);
      for (int k = 0; k < 3; k++) begin
         expect_pattern("t3_run", 1, 4, k, 1'b0);
         check_output();
      end
      apply_stimulus(1'b1, 1, 7, 4, 1'b0);
      expect_pattern("t3_dis_accept", 1, 4, 3, 1'b1);
      check_output();
      apply_stimulus(1'b0, 1, 7, 4, 1'b0);
      check_ready("t3_stall", 1'b0);
      cfg.cfg_ch = CHW'(2);
      check_ready("t3_other_ch", 1'b1);
      for (int k = 4; k < 8; k++) begin
         expect_pattern("t3_tail", 1, 4, k, 1'b1);
         check_output();
      end
      for (int k = 0; k < 4; k++) begin
         expect_ch("t3_off", 1, 1'b0, 1'b0, 1'b0);
         check_output();
      end

      // high=0: clock never rises.
      do_reset();
      apply_stimulus(1'b1, 2, 3, 0, 1'b1);
      expect_ch("t4_high0_accept", 2, 1'b0, 1'b0, 1'b1);
      check_output();
      apply_stimulus(1'b0, 2, 3, 0, 1'b1);
      for (int k = 0; k < 8; k++) begin
         expect_pattern("t4_high0", 2, 0, k % 4, 1'b0);
         check_output();
      end

      // high beyond the period: clock held high.
      do_reset();
      apply_stimulus(1'b1, 2, 3, 9, 1'b1);
      expect_ch("t4_high9_accept", 2, 1'b0, 1'b0, 1'b1);
      check_output();
      apply_stimulus(1'b0, 2, 3, 9, 1'b1);
      for (int k = 0; k < 8; k++) begin
         expect_pattern("t4_high9", 2, 9, k % 4, 1'b0);
         check_output();
      end

      // div=0: tick every cycle.
      do_reset();
      apply_stimulus(1'b1, 2, 0, 1, 1'b1);
      expect_ch("t4_div0_accept", 2, 1'b0, 1'b0, 1'b1);
      check_output();
      apply_stimulus(1'b0, 2, 0, 1, 1'b1);
      for (int k = 0; k < 5; k++) begin
         expect_pattern("t4_div0", 2, 1, 0, 1'b0);
         check_output();
      end

      // Channel index NCH: accepted and dropped.
      do_reset();
      apply_stimulus(1'b1, NCH, 1, 1, 1'b1);
      check_ready("t4_oob_ready", 1'b1);
      expect_all_idle("t4_oob_edge");
      check_output();
      apply_stimulus(1'b0, 0, 0, 0, 1'b0);
      expect_all_idle("t4_oob_after");
      check_output();

      // Back-to-back programming of two independent channels.
      do_reset();
      apply_stimulus(1'b1, 0, 2, 1, 1'b1);
      expect_ch("t5_a", 0, 1'b0, 1'b0, 1'b1);
      check_output();
      apply_stimulus(1'b1, 1, 4, 2, 1'b1);
      expect_pattern("t5_b_ch0", 0, 1, 0, 1'b0);
      expect_ch("t5_b_ch1", 1, 1'b0, 1'b0, 1'b1);
      check_output();
      apply_stimulus(1'b0, 0, 0, 0, 1'b0);
      for (int s = 1; s <= 12; s++) begin
         expect_pattern("t5_ch0", 0, 1, s % 3, 1'b0);
         expect_pattern("t5_ch1", 1, 2, (s - 1) % 5, 1'b0);
         check_output();
      end

      // Reset mid-operation with an update pending.
      apply_stimulus(1'b1, 0, 6, 2, 1'b1);
      expect_pattern("t6_pending", 0, 1, 13 % 3, 1'b1);
      check_output();
      apply_stimulus(1'b0, 0, 0, 0, 1'b0);
      rst_n = 1'b0;
      expect_all_idle("t6_reset_edge");
      check_output();
      rst_n = 1'b1;
      expect_all_idle("t6_after_reset");
      check_output();
      check_ready("t6_ready", 1'b1);

`ifdef CLK_DIV_GEN_SYNC_START_EN
      // Two channels out of phase, then sync_start aligns them.
      apply_stimulus(1'b1, 0, 3, 2, 1'b1);
      expect_ch("t7_a", 0, 1'b0, 1'b0, 1'b1);
      check_output();
      apply_stimulus(1'b1, 1, 4, 1, 1'b1);
      expect_pattern("t7_b_ch0", 0, 2, 0, 1'b0);
      expect_ch("t7_b_ch1", 1, 1'b0, 1'b0, 1'b1);
      check_output();
      apply_stimulus(1'b0, 0, 0, 0, 1'b0);
      expect_pattern("t7_run_ch0", 0, 2, 1, 1'b0);
      expect_pattern("t7_run_ch1", 1, 1, 0, 1'b0);
      check_output();
      expect_pattern("t7_run_ch0", 0, 2, 2, 1'b0);
      expect_pattern("t7_run_ch1", 1, 1, 1, 1'b0);
      check_output();
      sync_start = 1'b1;
      expect_pattern("t7_sync_ch0", 0, 2, 0, 1'b0);
      expect_pattern("t7_sync_ch1", 1, 1, 0, 1'b0);
      check_output();
      sync_start = 1'b0;
      expect_pattern("t7_post_ch0", 0, 2, 1, 1'b0);
      expect_pattern("t7_post_ch1", 1, 1, 1, 1'b0);
      check_output();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
